l2_mem_arbiter: RTL and testbench

Round-robin arbiter that shares the single-ported L2 memory array among `N_PORTS` requesters (e.g. host AXI path, cluster DMA, debug). It sits between the requesters' mem-style request/grant interfaces and the one memory port. It grants one request per cycle and routes the fixed-latency read response back to the granted port. Fairness is round-robin with a registered priority pointer.

---
 rtl/l2_mem_arb_pkg.sv | 24 ++
 rtl/l2_mem_arb_rr.sv | 60 ++++++
 rtl/l2_mem_arbiter.sv | 108 ++++++++++
 tb/tb_l2_mem_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_mem_arb_pkg.sv
// Shared types for the L2 memory arbiter: port index, perf counter
// type and the round-robin pointer increment helper.
package l2_mem_arb_pkg;

  localparam int N_PORTS_MAX = 8;
  localparam int IDX_W = $clog2(N_PORTS_MAX);

  typedef logic [IDX_W-1:0] port_idx_t;
  typedef logic [31:0]      perf_cnt_t;

  localparam perf_cnt_t PERF_CNT_MAX = 32'hFFFF_FFFF;

  // Next pointer after idx, wrapping to 0 after n-1.
  function automatic port_idx_t rr_next(
    input port_idx_t   idx,
    input int unsigned n
  );
    if (idx == port_idx_t'(n - 1)) begin
      return '0;
    end
    return idx + port_idx_t'(1);
  endfunction

endpackage

// File: rtl/l2_mem_arb_rr.sv
// Round-robin priority search plus the registered priority pointer.
// Ports: req (in), advance (in, pointer step), win_oh/win_idx (out).
module l2_mem_arb_rr
  import l2_mem_arb_pkg::*;
#(
  parameter int N_PORTS = 3
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [N_PORTS-1:0] req_i,
  input  logic               advance_i,
  output logic [N_PORTS-1:0] win_oh_o,
  output port_idx_t          win_idx_o
);

  localparam int SW = IDX_W + 1;

  port_idx_t              rr_q;
  logic [N_PORTS_MAX-1:0] req_pad;
  logic [SW-1:0]          sum;
  port_idx_t              cand;
  logic                   found;

  // First requester at or after rr_q, wrapping past N_PORTS-1.
  always_comb begin
    req_pad = '0;
    req_pad[N_PORTS-1:0] = req_i;
    found = 1'b0;
    win_idx_o = '0;
    sum = '0;
    cand = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      sum = {1'b0, rr_q} + SW'(k);
      if (sum >= SW'(N_PORTS)) begin
        sum = sum - SW'(N_PORTS);
      end
      cand = sum[IDX_W-1:0];
      if (!found && req_pad[cand]) begin
        found = 1'b1;
        win_idx_o = cand;
      end
    end
  end

  always_comb begin
    win_oh_o = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      win_oh_o[i] = found && (win_idx_o == port_idx_t'(i));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= '0;
    end else if (advance_i) begin
      rr_q <= rr_next(win_idx_o, N_PORTS);
    end
  end

endmodule

// File: rtl/l2_mem_arbiter.sv
// Round-robin arbiter sharing one L2 memory port among N_PORTS requesters.
// Ports: per-port req/we/addr/wdata/be in, gnt/rvalid out, shared rdata;
// memory cmd out, mem_gnt/mem_rdata in; perf_gnt_cnt out.
// Grant counters are built when L2_MEM_ARBITER_PERF_EN is defined.
module l2_mem_arbiter
  import l2_mem_arb_pkg::*;
#(
  parameter int N_PORTS = 3,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [N_PORTS-1:0]             req_i,
  input  logic [N_PORTS-1:0]             we_i,
  input  logic [N_PORTS-1:0][ADDR_W-1:0] addr_i,
  input  logic [N_PORTS-1:0][DATA_W-1:0] wdata_i,
  input  logic [N_PORTS-1:0][DATA_W/8-1:0] be_i,
  output logic [N_PORTS-1:0]             gnt_o,
  output logic [N_PORTS-1:0]             rvalid_o,
  output logic [DATA_W-1:0]              rdata_o,
  output logic                           mem_req_o,
  output logic                           mem_we_o,
  output logic [ADDR_W-1:0]              mem_addr_o,
  output logic [DATA_W-1:0]              mem_wdata_o,
  output logic [DATA_W/8-1:0]            mem_be_o,
  input  logic                           mem_gnt_i,
  input  logic [DATA_W-1:0]              mem_rdata_i,
  output perf_cnt_t [N_PORTS-1:0]        perf_gnt_cnt_o
);

  logic [N_PORTS-1:0] win_oh;
  port_idx_t          win_idx;
  logic               accept;
  logic               resp_vld_q;
  port_idx_t          resp_id_q;

  l2_mem_arb_rr #(
    .N_PORTS (N_PORTS)
  ) u_rr (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (req_i),
    .advance_i (accept),
    .win_oh_o  (win_oh),
    .win_idx_o (win_idx)
  );

  assign mem_req_o = |req_i;

  // Memory ignores requests during reset, so no grant is issued then.
  assign gnt_o  = win_oh & {N_PORTS{mem_gnt_i & rst_ni}};
  assign accept = |gnt_o;

  // One-hot select; all-zero winner drives a zero command.
  always_comb begin
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (win_oh[i]) begin
        mem_we_o    = we_i[i];
        mem_addr_o  = addr_i[i];
        mem_wdata_o = wdata_i[i];
        mem_be_o    = be_i[i];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resp_vld_q <= 1'b0;
      resp_id_q  <= '0;
    end else begin
      resp_vld_q <= accept;
      if (accept) begin
        resp_id_q <= win_idx;
      end
    end
  end

  always_comb begin
    rvalid_o = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      rvalid_o[i] = resp_vld_q && (resp_id_q == port_idx_t'(i));
    end
  end

  assign rdata_o = mem_rdata_i;

`ifdef L2_MEM_ARBITER_PERF_EN
  for (genvar g = 0; g < N_PORTS; g++) begin : g_perf
    perf_cnt_t cnt_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q <= '0;
      end else if (gnt_o[g] && (cnt_q != PERF_CNT_MAX)) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
    assign perf_gnt_cnt_o[g] = cnt_q;
  end
`else
  assign perf_gnt_cnt_o = '0;
`endif

endmodule

// File: tb/tb_l2_mem_arbiter.sv
// Directed bench for l2_mem_arbiter with a 1-cycle-latency memory model.
// Expected perf values follow L2_MEM_ARBITER_PERF_EN.
module tb_l2_mem_arbiter;
  import l2_mem_arb_pkg::*;

  logic                 clk_i = 1'b0;
  logic                 rst_ni;
  logic [2:0]           req_i;
  logic [2:0]           we_i;
  logic [2:0][31:0]     addr_i;
  logic [2:0][63:0]     wdata_i;
  logic [2:0][7:0]      be_i;
  logic [2:0]           gnt_o;
  logic [2:0]           rvalid_o;
  logic [63:0]          rdata_o;
  logic                 mem_req_o;
  logic                 mem_we_o;
  logic [31:0]          mem_addr_o;
  logic [63:0]          mem_wdata_o;
  logic [7:0]           mem_be_o;
  logic                 mem_gnt_i;
  logic [63:0]          mem_rdata_i = '0;
  perf_cnt_t [2:0]      perf_gnt_cnt_o;

  int total = 0;
  int bad = 0;

  always #5 clk_i = ~clk_i;

  l2_mem_arbiter #(
    .N_PORTS (3),
    .ADDR_W  (32),
    .DATA_W  (64)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .req_i          (req_i),
    .we_i           (we_i),
    .addr_i         (addr_i),
    .wdata_i        (wdata_i),
    .be_i           (be_i),
    .gnt_o          (gnt_o),
    .rvalid_o       (rvalid_o),
    .rdata_o        (rdata_o),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_be_o       (mem_be_o),
    .mem_gnt_i      (mem_gnt_i),
    .mem_rdata_i    (mem_rdata_i),
    .perf_gnt_cnt_o (perf_gnt_cnt_o)
  );

  function automatic logic [63:0] mdata(input logic [31:0] a);
    return {~a, a ^ 32'h5A5A_0000};
  endfunction

  always @(posedge clk_i) begin
    if (rst_ni && mem_req_o && mem_gnt_i) begin
      mem_rdata_i <= mdata(mem_addr_o);
    end else begin
      mem_rdata_i <= '0;
    end
  end

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic next();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    next();
    rst_ni = 1'b0;
    req_i = '0;
    next();
    rst_ni = 1'b1;
  endtask

  logic [31:0] exp_perf [3];

  initial begin
    rst_ni = 1'b0;
    req_i = '0;
    we_i = '0;
    addr_i = '0;
    wdata_i = '0;
    be_i = '0;
    mem_gnt_i = 1'b1;

    // reset: requests are not granted
    next();
    req_i = 3'b111;
    #1;
    chk("rst_gnt", 64'(gnt_o), 0);
    chk("rst_rvalid", 64'(rvalid_o), 0);
    chk("rst_memreq", 64'(mem_req_o), 1);
    chk("rst_perf0", 64'(perf_gnt_cnt_o[0]), 0);
    next();
    rst_ni = 1'b1;
    req_i = '0;
    #1;
    chk("idle_memreq", 64'(mem_req_o), 0);
    chk("idle_addr", 64'(mem_addr_o), 0);

    // single port 1, back-to-back reads
    for (int c = 0; c < 4; c++) begin
      next();
      req_i = 3'b010;
      addr_i[1] = 32'(c * 8);
      #1;
      chk("p1_gnt", 64'(gnt_o), 64'h2);
      chk("p1_addr", 64'(mem_addr_o), 64'(c * 8));
      chk("p1_we", 64'(mem_we_o), 0);
      chk("p1_rvalid", 64'(rvalid_o), (c == 0) ? 64'h0 : 64'h2);
      if (c > 0) chk("p1_rdata", rdata_o, mdata(32'((c - 1) * 8)));
    end
    next();
    req_i = '0;
    #1;
    chk("p1_last_rvalid", 64'(rvalid_o), 64'h2);
    chk("p1_last_rdata", rdata_o, mdata(32'h18));
    chk("p1_idle_gnt", 64'(gnt_o), 0);

    // all ports, round-robin order from reset
    do_reset();
    addr_i[0] = 32'h100;
    addr_i[1] = 32'h200;
    addr_i[2] = 32'h300;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) next();
      req_i = 3'b111;
      #1;
      chk("rr_gnt", 64'(gnt_o), 64'(1 << (c % 3)));
      chk("rr_addr", 64'(mem_addr_o), 64'(32'h100 * ((c % 3) + 1)));
    end

    // stall in the middle of continuous requests
    next();
    #1;
    chk("st_pre_gnt0", 64'(gnt_o), 64'h1);
    next();
    #1;
    chk("st_pre_gnt1", 64'(gnt_o), 64'h2);
    for (int s = 0; s < 3; s++) begin
      next();
      mem_gnt_i = 1'b0;
      #1;
      chk("st_gnt", 64'(gnt_o), 0);
      chk("st_rvalid", 64'(rvalid_o), (s == 0) ? 64'h2 : 64'h0);
      chk("st_memreq", 64'(mem_req_o), 1);
    end
    next();
    mem_gnt_i = 1'b1;
    #1;
    chk("st_rel_gnt", 64'(gnt_o), 64'h4);
    chk("st_rel_rvalid", 64'(rvalid_o), 0);
    next();
    #1;
    chk("st_rel_gnt2", 64'(gnt_o), 64'h1);
    chk("st_rel_rvalid2", 64'(rvalid_o), 64'h4);

    // port 2 write, then port 0 read of same address
    next();
    req_i = 3'b100;
    we_i[2] = 1'b1;
    addr_i[2] = 32'h40;
    wdata_i[2] = 64'hA5A5_A5A5_A5A5_A5A5;
    be_i[2] = 8'hF0;
    #1;
    chk("wr_gnt", 64'(gnt_o), 64'h4);
    chk("wr_we", 64'(mem_we_o), 1);
    chk("wr_be", 64'(mem_be_o), 64'hF0);
    chk("wr_wdata", mem_wdata_o, 64'hA5A5_A5A5_A5A5_A5A5);
    chk("wr_addr", 64'(mem_addr_o), 64'h40);
    chk("wr_prev_rvalid", 64'(rvalid_o), 64'h1);
    next();
    req_i = 3'b001;
    we_i[2] = 1'b0;
    addr_i[0] = 32'h40;
    be_i[0] = 8'hFF;
    #1;
    chk("rd_gnt", 64'(gnt_o), 64'h1);
    chk("rd_we", 64'(mem_we_o), 0);
    chk("rd_be", 64'(mem_be_o), 64'hFF);
    chk("wr_rvalid", 64'(rvalid_o), 64'h4);
    next();
    req_i = '0;
    #1;
    chk("rd_rvalid", 64'(rvalid_o), 64'h1);
    chk("rd_rdata", rdata_o, mdata(32'h40));

    // reset right after a grant to port 1
    next();
    req_i = 3'b010;
    addr_i[1] = 32'h80;
    #1;
    chk("mr_gnt", 64'(gnt_o), 64'h2);
    next();
    rst_ni = 1'b0;
    req_i = '0;
    #1;
    chk("mr_rvalid0", 64'(rvalid_o), 0);
    next();
    #1;
    chk("mr_rvalid1", 64'(rvalid_o), 0);
    next();
    rst_ni = 1'b1;
    req_i = 3'b011;
    addr_i[0] = 32'h200;
    #1;
    chk("mr_post_gnt", 64'(gnt_o), 64'h1);
    chk("mr_post_addr", 64'(mem_addr_o), 64'h200);
    next();
    #1;
    chk("mr_post_gnt2", 64'(gnt_o), 64'h2);
    chk("mr_post_rvalid", 64'(rvalid_o), 64'h1);

    // grant counters
    do_reset();
    #1;
    chk("pf_rst0", 64'(perf_gnt_cnt_o[0]), 0);
    chk("pf_rst1", 64'(perf_gnt_cnt_o[1]), 0);
    for (int c = 0; c < 15; c++) begin
      if (c > 0) next();
      req_i = (c < 10) ? 3'b001 : 3'b100;
      #1;
      chk("pf_gnt", 64'(gnt_o), (c < 10) ? 64'h1 : 64'h4);
    end
    next();
    req_i = '0;
    #1;
`ifdef L2_MEM_ARBITER_PERF_EN
    exp_perf[0] = 32'd10;
    exp_perf[1] = 32'd0;
    exp_perf[2] = 32'd5;
`else
    exp_perf[0] = 32'd0;
    exp_perf[1] = 32'd0;
    exp_perf[2] = 32'd0;
`endif
    chk("pf_cnt0", 64'(perf_gnt_cnt_o[0]), 64'(exp_perf[0]));
    chk("pf_cnt1", 64'(perf_gnt_cnt_o[1]), 64'(exp_perf[1]));
    chk("pf_cnt2", 64'(perf_gnt_cnt_o[2]), 64'(exp_perf[2]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
